video_timing_gen: RTL and testbench

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_pkg.sv | 65 ++++++
 rtl/video_timing_gen_axis.sv | 89 ++++++++
 rtl/video_timing_gen.sv | 103 ++++++++++
 tb/tb_video_timing_gen.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// video_timing_pkg
//   Shared constants and helpers for the video timing generator.
//   - Standard mode constants (640x480p60 and 1280x720p60) in pixels / lines.
//   - Derived-constant functions for one axis. An axis runs from STA up to
//     ACT_END in this order: front porch, sync, back porch, then active.
//     The blanking interval therefore occupies negative coordinates, and the
//     active region starts at coordinate 0.
//   - fits_signed(): elaboration-time range check for coordinate widths.
package video_timing_pkg;

    // 640x480p60 (25.175 MHz pixel clock)
    localparam int VGA_H_RES  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;
    localparam int VGA_V_RES  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;

    // 1280x720p60 (74.25 MHz pixel clock), normally used with active-high syncs
    localparam int HD_H_RES   = 1280;
    localparam int HD_H_FP    = 110;
    localparam int HD_H_SYNC  = 40;
    localparam int HD_H_BP    = 220;
    localparam int HD_V_RES   = 720;
    localparam int HD_V_FP    = 5;
    localparam int HD_V_SYNC  = 5;
    localparam int HD_V_BP    = 20;

    // First coordinate of a line/frame: the whole blanking interval lies below 0.
    function automatic int axis_sta(input int fp, input int sync, input int bp);
        return -(fp + sync + bp);
    endfunction

    // First coordinate inside the sync pulse.
    function automatic int axis_sync_sta(input int fp, input int sync, input int bp);
        return axis_sta(fp, sync, bp) + fp;
    endfunction

    // First coordinate after the sync pulse (exclusive end).
    function automatic int axis_sync_end(input int fp, input int sync, input int bp);
        return axis_sync_sta(fp, sync, bp) + sync;
    endfunction

    // Last active coordinate; the counter wraps after this one.
    function automatic int axis_act_end(input int res);
        return res - 1;
    endfunction

    // Number of counter steps in one full period of the axis.
    function automatic int axis_total(input int res, input int fp, input int sync, input int bp);
        return res + fp + sync + bp;
    endfunction

    // True when value is representable as a signed number of the given width.
    function automatic bit fits_signed(input int value, input int width);
        longint lo;
        longint hi;
        lo = -(longint'(1) <<< (width - 1));
        hi = (longint'(1) <<< (width - 1)) - 1;
        return (longint'(value) >= lo) && (longint'(value) <= hi);
    endfunction

endpackage

// File: rtl/video_timing_gen_axis.sv
// timing_axis
//   One axis (horizontal or vertical) of the video timing generator:
//   a signed position counter that steps from STA to ACT_END and wraps,
//   plus the sync and active decode for that axis.
//
//   The sync output is registered from the *next* position so that it lines
//   up with pos in the same cycle. The active decode and the wrap condition
//   are offered combinationally so the parent can build its own registered,
//   cross-axis flags from the same next-state values.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset; parks pos at ACT_END
//   en           in   advance the counter on this edge
//   pos          out  current signed coordinate (registered)
//   wrap         out  pos is at ACT_END, i.e. the next step returns to STA
//   active_next  out  position after this edge will be >= 0
//   sync         out  sync pulse at polarity POL (registered)
module timing_axis
    import video_timing_pkg::*;
#(
    parameter int CORDW = 16,
    parameter int RES   = 640,
    parameter int FP    = 16,
    parameter int SYNC  = 96,
    parameter int BP    = 48,
    parameter bit POL   = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    output logic signed [CORDW-1:0] pos,
    output logic                    wrap,
    output logic                    active_next,
    output logic                    sync
);

    localparam int STA_I      = axis_sta(FP, SYNC, BP);
    localparam int SYNC_STA_I = axis_sync_sta(FP, SYNC, BP);
    localparam int SYNC_END_I = axis_sync_end(FP, SYNC, BP);
    localparam int ACT_END_I  = axis_act_end(RES);

    // Every other constant lies between STA and ACT_END, so checking the two
    // extremes is enough to guarantee all compares are exact at CORDW.
    generate
        if (!fits_signed(STA_I, CORDW) || !fits_signed(ACT_END_I, CORDW)) begin : g_bad_cordw
            $error("timing_axis: STA %0d or ACT_END %0d does not fit %0d-bit signed",
                   STA_I, ACT_END_I, CORDW);
        end
        if (RES < 1 || SYNC < 1 || axis_total(RES, FP, SYNC, BP) < 2) begin : g_bad_timing
            $error("timing_axis: degenerate timing RES=%0d SYNC=%0d", RES, SYNC);
        end
    endgenerate

    localparam logic signed [CORDW-1:0] A_STA      = CORDW'(STA_I);
    localparam logic signed [CORDW-1:0] A_SYNC_STA = CORDW'(SYNC_STA_I);
    localparam logic signed [CORDW-1:0] A_SYNC_END = CORDW'(SYNC_END_I);
    localparam logic signed [CORDW-1:0] A_ACT_END  = CORDW'(ACT_END_I);
    localparam logic signed [CORDW-1:0] A_ZERO     = CORDW'(0);
    localparam logic signed [CORDW-1:0] A_ONE      = CORDW'(1);

    logic signed [CORDW-1:0] pos_next;
    logic                    sync_next;

    assign wrap = (pos == A_ACT_END);

    always_comb begin
        pos_next = pos;
        if (en) begin
            pos_next = wrap ? A_STA : (pos + A_ONE);
        end
    end

    assign active_next = (pos_next >= A_ZERO);
    assign sync_next   = (pos_next >= A_SYNC_STA) && (pos_next < A_SYNC_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            // Parked on the last active coordinate so that the first edge
            // after reset wraps straight to STA.
            pos  <= A_ACT_END;
            sync <= ~POL;
        end else begin
            pos  <= pos_next;
            sync <= sync_next ? POL : ~POL;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Raster timing generator. Produces signed pixel coordinates (sx, sy),
//   horizontal/vertical sync, the active-video enable and start-of-line /
//   start-of-frame pulses. Blanking is at negative coordinates; the active
//   picture is sx = 0..H_RES-1, sy = 0..V_RES-1.
//
//   Two timing_axis instances do the counting. The vertical axis steps only
//   on the edge where the horizontal axis wraps, so sx and sy roll over on
//   the same edge. Every output is a flop, and every flag is computed from
//   the same next-state values as the coordinates, so flags and coordinates
//   in a given cycle always describe the same pixel.
//
// Ports
//   video_clk_pix  in   pixel clock, all logic on its rising edge
//   rst            in   synchronous active-high reset
//   sx, sy         out  current signed pixel coordinates (CORDW bits)
//   hsync, vsync   out  sync pulses at polarity H_POL / V_POL (1 = active high)
//   video_enable   out  high only while sx >= 0 and sy >= 0
//   line_start     out  one-cycle pulse on the first pixel of every line
//   frame_start    out  one-cycle pulse on the first pixel of every frame
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int CORDW  = 16,
    parameter int H_RES  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_RES  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter bit H_POL  = 1'b0,
    parameter bit V_POL  = 1'b0
) (
    input  logic                    video_clk_pix,
    input  logic                    rst,
    output logic signed [CORDW-1:0] sx,
    output logic signed [CORDW-1:0] sy,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    video_enable,
    output logic                    line_start,
    output logic                    frame_start
);

    logic h_wrap;
    logic v_wrap;
    logic h_active_next;
    logic v_active_next;

    timing_axis #(
        .CORDW (CORDW),
        .RES   (H_RES),
        .FP    (H_FP),
        .SYNC  (H_SYNC),
        .BP    (H_BP),
        .POL   (H_POL)
    ) u_h_axis (
        .clk         (video_clk_pix),
        .rst         (rst),
        .en          (1'b1),
        .pos         (sx),
        .wrap        (h_wrap),
        .active_next (h_active_next),
        .sync        (hsync)
    );

    timing_axis #(
        .CORDW (CORDW),
        .RES   (V_RES),
        .FP    (V_FP),
        .SYNC  (V_SYNC),
        .BP    (V_BP),
        .POL   (V_POL)
    ) u_v_axis (
        .clk         (video_clk_pix),
        .rst         (rst),
        .en          (h_wrap),
        .pos         (sy),
        .wrap        (v_wrap),
        .active_next (v_active_next),
        .sync        (vsync)
    );

    // The horizontal axis steps every cycle, so a wrap now means the next sx
    // is H_STA (start of line). Both axes wrapping together means the next
    // pixel is (H_STA, V_STA), the start of a frame. Reset parks both axes
    // at their last coordinate, so the first edge after reset also produces
    // both pulses.
    always_ff @(posedge video_clk_pix) begin
        if (rst) begin
            video_enable <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            video_enable <= h_active_next && v_active_next;
            line_start   <= h_wrap;
            frame_start  <= h_wrap && v_wrap;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen
//   Directed bench for video_timing_gen. Three instances share one clock:
//   the default 640x480 mode, a tiny mode that makes whole frames cheap to
//   walk through, and 1280x720 with active-high syncs. Expected coordinates
//   are rebuilt from a cycle counter; expected flags come from hand-computed
//   boundaries for each mode.
module tb_video_timing_gen;
    import video_timing_pkg::*;

    localparam int CORDW = 16;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_vga;
    logic rst_small;
    logic rst_hd;

    // 640x480 instance
    logic signed [CORDW-1:0] vga_sx, vga_sy;
    logic vga_hs, vga_vs, vga_de, vga_ls, vga_fs;
    // tiny instance: line 16+2+4+3 = 25, frame 8+2+2+3 = 15 lines = 375 cycles
    logic signed [CORDW-1:0] sm_sx, sm_sy;
    logic sm_hs, sm_vs, sm_de, sm_ls, sm_fs;
    // 1280x720 instance, active-high syncs
    logic signed [CORDW-1:0] hd_sx, hd_sy;
    logic hd_hs, hd_vs, hd_de, hd_ls, hd_fs;

    video_timing_gen #(.CORDW(CORDW)) dut_vga (
        .video_clk_pix (clk),
        .rst           (rst_vga),
        .sx            (vga_sx),
        .sy            (vga_sy),
        .hsync         (vga_hs),
        .vsync         (vga_vs),
        .video_enable  (vga_de),
        .line_start    (vga_ls),
        .frame_start   (vga_fs)
    );

    video_timing_gen #(
        .CORDW (CORDW),
        .H_RES (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
        .V_RES (8),  .V_FP (2), .V_SYNC (2), .V_BP (3)
    ) dut_small (
        .video_clk_pix (clk),
        .rst           (rst_small),
        .sx            (sm_sx),
        .sy            (sm_sy),
        .hsync         (sm_hs),
        .vsync         (sm_vs),
        .video_enable  (sm_de),
        .line_start    (sm_ls),
        .frame_start   (sm_fs)
    );

    video_timing_gen #(
        .CORDW  (CORDW),
        .H_RES  (HD_H_RES), .H_FP (HD_H_FP), .H_SYNC (HD_H_SYNC), .H_BP (HD_H_BP),
        .V_RES  (HD_V_RES), .V_FP (HD_V_FP), .V_SYNC (HD_V_SYNC), .V_BP (HD_V_BP),
        .H_POL  (1'b1),
        .V_POL  (1'b1)
    ) dut_hd (
        .video_clk_pix (clk),
        .rst           (rst_hd),
        .sx            (hd_sx),
        .sy            (hd_sy),
        .hsync         (hd_hs),
        .vsync         (hd_vs),
        .video_enable  (hd_de),
        .line_start    (hd_ls),
        .frame_start   (hd_fs)
    );

    // scoreboard state
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic signed [63:0] actual,
                            input logic signed [63:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // driver tasks: advance one edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_sx, exp_sy;
    int hs_cnt, hs_bad, vs_cnt, vs_bad, ls_cnt, ls_bad, fs_bad, de_cnt, de_bad, pos_bad;
    int first_x, first_y, last_x, last_y, last_ls;
    bit seen_de, found;

    initial begin
        rst_vga   = 1'b1;
        rst_small = 1'b1;
        rst_hd    = 1'b1;
        repeat (3) tick();

        // ---------------- 640x480 ----------------
        check_eq("vga_rst_sx", vga_sx, 639);
        check_eq("vga_rst_sy", vga_sy, 479);
        check_eq("vga_rst_de", vga_de, 0);
        check_eq("vga_rst_hs", vga_hs, 1);
        check_eq("vga_rst_vs", vga_vs, 1);
        check_eq("vga_rst_ls", vga_ls, 0);
        check_eq("vga_rst_fs", vga_fs, 0);

        rst_vga = 1'b0;
        hs_cnt = 0; hs_bad = 0; vs_cnt = 0; vs_bad = 0; ls_cnt = 0; ls_bad = 0;
        fs_bad = 0; de_cnt = 0; pos_bad = 0;
        for (int c = 0; c < 12 * 800; c++) begin
            tick();
            exp_sx = -160 + (c % 800);
            exp_sy = -45 + (c / 800);
            if (c == 0) begin
                check_eq("vga_c1_sx", vga_sx, -160);
                check_eq("vga_c1_sy", vga_sy, -45);
                check_eq("vga_c1_fs", vga_fs, 1);
                check_eq("vga_c1_ls", vga_ls, 1);
            end
            if (c == 1) begin
                check_eq("vga_c2_sx", vga_sx, -159);
                check_eq("vga_c2_fs", vga_fs, 0);
                check_eq("vga_c2_ls", vga_ls, 0);
            end
            if (c == 15)  check_eq("vga_hs_before", vga_hs, 1);
            if (c == 16)  check_eq("vga_hs_first",  vga_hs, 0);
            if (c == 111) check_eq("vga_hs_last",   vga_hs, 0);
            if (c == 112) check_eq("vga_hs_after",  vga_hs, 1);
            if (vga_sx != exp_sx || vga_sy != exp_sy) pos_bad++;
            if (vga_hs == 1'b0) hs_cnt++;
            if (vga_hs != !(exp_sx >= -144 && exp_sx <= -49)) hs_bad++;
            if (vga_vs == 1'b0) vs_cnt++;
            if (vga_vs != !(exp_sy >= -35 && exp_sy <= -34)) vs_bad++;
            if (vga_ls) ls_cnt++;
            if (vga_ls != (exp_sx == -160)) ls_bad++;
            if (vga_fs != (c == 0)) fs_bad++;
            if (vga_de) de_cnt++;
        end
        check_eq("vga_pos_track", pos_bad, 0);
        check_eq("vga_hs_low_cnt", hs_cnt, 12 * 96);
        check_eq("vga_hs_window", hs_bad, 0);
        check_eq("vga_vs_low_cnt", vs_cnt, 1600);
        check_eq("vga_vs_window", vs_bad, 0);
        check_eq("vga_ls_cnt", ls_cnt, 12);
        check_eq("vga_ls_pos", ls_bad, 0);
        check_eq("vga_fs_pos", fs_bad, 0);
        check_eq("vga_de_blank", de_cnt, 0);

        // ---------------- tiny mode: whole frames ----------------
        rst_small = 1'b0;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd375);
        exp_q.push_back(32'd750);
        hs_cnt = 0; vs_cnt = 0; ls_cnt = 0; de_cnt = 0; de_bad = 0; pos_bad = 0;
        seen_de = 1'b0; first_x = 99; first_y = 99; last_x = 99; last_y = 99;
        for (int c = 0; c <= 750; c++) begin
            tick();
            exp_sx = -9 + (c % 25);
            exp_sy = -7 + ((c / 25) % 15);
            if (sm_sx != exp_sx || sm_sy != exp_sy) pos_bad++;
            if (sm_fs) begin
                if (exp_q.size() == 0) check_eq("sm_fs_extra", c, -1);
                else check_eq("sm_fs_cycle", c, exp_q.pop_front());
            end
            if (sm_de != (exp_sx >= 0 && exp_sy >= 0)) de_bad++;
            if (c < 375) begin
                if (sm_ls) ls_cnt++;
                if (sm_hs == 1'b0) hs_cnt++;
                if (sm_vs == 1'b0) vs_cnt++;
                if (sm_de) begin
                    de_cnt++;
                    if (!seen_de) begin
                        seen_de = 1'b1;
                        first_x = sm_sx;
                        first_y = sm_sy;
                    end
                    last_x = sm_sx;
                    last_y = sm_sy;
                end
            end
        end
        check_eq("sm_fs_missing", exp_q.size(), 0);
        check_eq("sm_pos_track", pos_bad, 0);
        check_eq("sm_ls_per_frame", ls_cnt, 15);
        check_eq("sm_hs_low_cnt", hs_cnt, 15 * 4);
        check_eq("sm_vs_low_cnt", vs_cnt, 2 * 25);
        check_eq("sm_de_cnt", de_cnt, 128);
        check_eq("sm_de_window", de_bad, 0);
        check_eq("sm_de_first_x", first_x, 0);
        check_eq("sm_de_first_y", first_y, 0);
        check_eq("sm_de_last_x", last_x, 15);
        check_eq("sm_de_last_y", last_y, 7);

        // mid-frame reset pulse at (10,5)
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            tick();
            if (sm_sx == 10 && sm_sy == 5) found = 1'b1;
        end
        check_eq("sm_reach_10_5", found, 1);
        rst_small = 1'b1;
        tick();
        rst_small = 1'b0;
        check_eq("sm_midrst_sx", sm_sx, 15);
        check_eq("sm_midrst_sy", sm_sy, 7);
        check_eq("sm_midrst_de", sm_de, 0);
        check_eq("sm_midrst_ls", sm_ls, 0);
        check_eq("sm_midrst_fs", sm_fs, 0);
        check_eq("sm_midrst_hs", sm_hs, 1);
        check_eq("sm_midrst_vs", sm_vs, 1);
        tick();
        check_eq("sm_after_sx", sm_sx, -9);
        check_eq("sm_after_sy", sm_sy, -7);
        check_eq("sm_after_fs", sm_fs, 1);
        check_eq("sm_after_ls", sm_ls, 1);
        tick();
        check_eq("sm_next_sx", sm_sx, -8);
        check_eq("sm_next_fs", sm_fs, 0);

        // ---------------- 1280x720, active-high syncs ----------------
        check_eq("hd_rst_sx", hd_sx, 1279);
        check_eq("hd_rst_sy", hd_sy, 719);
        check_eq("hd_rst_hs", hd_hs, 0);
        check_eq("hd_rst_vs", hd_vs, 0);
        rst_hd = 1'b0;
        hs_cnt = 0; hs_bad = 0; vs_cnt = 0; vs_bad = 0; ls_cnt = 0; ls_bad = 0;
        pos_bad = 0; last_ls = -1;
        for (int c = 0; c < 11 * 1650; c++) begin
            tick();
            exp_sx = -370 + (c % 1650);
            exp_sy = -30 + (c / 1650);
            if (c == 0) check_eq("hd_c1_fs", hd_fs, 1);
            if (hd_sx != exp_sx || hd_sy != exp_sy) pos_bad++;
            if (hd_hs) hs_cnt++;
            if (hd_hs != (exp_sx >= -260 && exp_sx < -220)) hs_bad++;
            if (hd_vs) vs_cnt++;
            if (hd_vs != (exp_sy >= -25 && exp_sy < -20)) vs_bad++;
            if (hd_ls) begin
                ls_cnt++;
                if (last_ls >= 0 && (c - last_ls) != 1650) ls_bad++;
                last_ls = c;
            end
        end
        check_eq("hd_pos_track", pos_bad, 0);
        check_eq("hd_hs_high_cnt", hs_cnt, 11 * 40);
        check_eq("hd_hs_window", hs_bad, 0);
        check_eq("hd_vs_high_cnt", vs_cnt, 5 * 1650);
        check_eq("hd_vs_window", vs_bad, 0);
        check_eq("hd_ls_cnt", ls_cnt, 11);
        check_eq("hd_ls_period", ls_bad, 0);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded time limit, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
